sip_bitplane_sched: RTL

//  Bit-plane scheduler and accumulator for the XNOR SIP dot-product datapath (32-lane MUL array + adder tree).

---
 rtl/sip_bitplane_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sip_bitplane_sched.sv
// rtl/sip_bitplane_sched.sv - bit-plane pair scheduler and shifted/signed sum accumulator for the XNOR SIP datapath
module sip_bitplane_sched #(
    parameter int BITS_SUM = 8,
    parameter int BITS_ACC = 24,
    parameter int SUM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [1:0]          i_act_prec,
    input  logic [1:0]          i_wgt_prec,
    input  logic                i_act_signed,
    input  logic                i_wgt_signed,
    input  logic                i_bin,
    output logic                o_busy,
    output logic                o_plane_req,
    output logic [2:0]          o_act_plane,
    output logic [2:0]          o_wgt_plane,
    output logic                o_sign_i,
    output logic                o_bin,
    input  logic [BITS_SUM-1:0] i_sum,
    output logic [BITS_ACC-1:0] o_result,
    output logic                o_result_valid,
    input  logic                i_result_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(SUM_LAT - 1);

    state_t r_state;

    // Job configuration latched at start: highest plane index per operand and effective signedness
    logic [2:0] r_act_last;
    logic [2:0] r_wgt_last;
    logic       r_act_signed;
    logic       r_wgt_signed;
    logic [7:0] r_drain_cnt;

    // Per-request side info delayed to line up with the returning adder-tree sum
    logic [SUM_LAT-1:0]      r_pipe_vld;
    logic [SUM_LAT-1:0]      r_pipe_neg;
    logic [SUM_LAT-1:0][3:0] r_pipe_sh;

    logic [BITS_ACC-1:0] r_acc;

    logic                w_start;
    logic [2:0]          w_new_act_last;
    logic [2:0]          w_new_wgt_last;
    logic                w_last_pair;
    logic                w_wgt_wrap;
    logic [2:0]          w_next_act;
    logic [2:0]          w_next_wgt;
    logic [BITS_ACC-1:0] w_sum_ext;
    logic [BITS_ACC-1:0] w_shifted;
    logic [BITS_ACC-1:0] w_contrib;
    logic [BITS_ACC-1:0] w_acc_next;

    // Precision code 0..3 maps to a plane count of 1,2,4,8; return the last plane index
    function automatic logic [2:0] f_last_plane(input logic [1:0] prec);
        case (prec)
            2'd0:    f_last_plane = 3'd0;
            2'd1:    f_last_plane = 3'd1;
            2'd2:    f_last_plane = 3'd3;
            default: f_last_plane = 3'd7;
        endcase
    endfunction

    // Start decode, plane stepping (act outer, weight inner) and the shifted/negated contribution
    always_comb begin
        w_start        = (r_state == S_IDLE) && i_start;
        w_new_act_last = i_bin ? 3'd0 : f_last_plane(i_act_prec);
        w_new_wgt_last = i_bin ? 3'd0 : f_last_plane(i_wgt_prec);
        w_wgt_wrap     = (o_wgt_plane == r_wgt_last);
        w_last_pair    = w_wgt_wrap && (o_act_plane == r_act_last);
        w_next_act     = w_wgt_wrap ? (o_act_plane + 3'd1) : o_act_plane;
        w_next_wgt     = w_wgt_wrap ? 3'd0 : (o_wgt_plane + 3'd1);
        w_sum_ext      = {{(BITS_ACC-BITS_SUM){i_sum[BITS_SUM-1]}}, i_sum};
        w_shifted      = w_sum_ext << r_pipe_sh[SUM_LAT-1];
        w_contrib      = r_pipe_neg[SUM_LAT-1] ? (-w_shifted) : w_shifted;
        w_acc_next     = r_pipe_vld[SUM_LAT-1] ? (r_acc + w_contrib) : r_acc;
    end

    // Job FSM with registered datapath controls and result handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_act_last     <= 3'd0;
            r_wgt_last     <= 3'd0;
            r_act_signed   <= 1'b0;
            r_wgt_signed   <= 1'b0;
            r_drain_cnt    <= 8'd0;
            o_busy         <= 1'b0;
            o_plane_req    <= 1'b0;
            o_act_plane    <= 3'd0;
            o_wgt_plane    <= 3'd0;
            o_sign_i       <= 1'b0;
            o_bin          <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_ISSUE;
                        r_act_last   <= w_new_act_last;
                        r_wgt_last   <= w_new_wgt_last;
                        r_act_signed <= i_act_signed & ~i_bin;
                        r_wgt_signed <= i_wgt_signed & ~i_bin;
                        o_bin        <= i_bin;
                        o_busy       <= 1'b1;
                        o_plane_req  <= 1'b1;
                        o_act_plane  <= 3'd0;
                        o_wgt_plane  <= 3'd0;
                        o_sign_i     <= i_act_signed & ~i_bin & (w_new_act_last == 3'd0);
                    end
                end
                S_ISSUE: begin
                    if (w_last_pair) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= 8'd0;
                        o_plane_req <= 1'b0;
                        o_act_plane <= 3'd0;
                        o_wgt_plane <= 3'd0;
                        o_sign_i    <= 1'b0;
                    end else begin
                        o_act_plane <= w_next_act;
                        o_wgt_plane <= w_next_wgt;
                        o_sign_i    <= r_act_signed & (w_next_act == r_act_last);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state        <= S_DONE;
                        o_result       <= w_acc_next;
                        o_result_valid <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 8'd1;
                    end
                end
                default: begin
                    if (i_result_ready) begin
                        r_state        <= S_IDLE;
                        o_result_valid <= 1'b0;
                        o_busy         <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Delay each request's shift/negate tag by SUM_LAT and fold the matching sum into the accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_neg <= '0;
            r_pipe_sh  <= '0;
            r_acc      <= '0;
        end else begin
            r_pipe_vld[0] <= o_plane_req;
            r_pipe_sh[0]  <= 4'(o_act_plane) + 4'(o_wgt_plane);
            r_pipe_neg[0] <= r_wgt_signed & (o_wgt_plane == r_wgt_last);
            for (int i = SUM_LAT - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_sh[i]  <= r_pipe_sh[i-1];
                r_pipe_neg[i] <= r_pipe_neg[i-1];
            end
            if (w_start) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end

endmodule
